// File: rtl/tt_sweep.sv
// tt_sweep: walks a 7-input function through vectors 127..0 and streams its truth table as 16 bytes
//   clk       rising-edge clock for all state
//   rst       synchronous active-high reset
//   start     begin a sweep (only honoured in IDLE)
//   x0..x6    vector presented to the external function (x0 = LSB)
//   f_in      function value for the vector on x0..x6
//   tt_data   truth-table byte, MSB = highest vector of the byte
//   tt_valid  tt_data holds a byte
//   tt_ready  consumer takes the byte when tt_valid & tt_ready
//   busy      high outside IDLE
//   done      one-cycle pulse at sweep end
// Build option: define TT_SWEEP_REG_IN_EN to register f_in; each vector is then held
// for a present cycle and a capture cycle.
module tt_sweep (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       x0,
  output logic       x1,
  output logic       x2,
  output logic       x3,
  output logic       x4,
  output logic       x5,
  output logic       x6,
  input  logic       f_in,
  output logic [7:0] tt_data,
  output logic       tt_valid,
  input  logic       tt_ready,
  output logic       busy,
  output logic       done
);
  localparam logic [1:0] IDLE = 2'd0, SWEEP = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [6:0] idx_q, idx_d, sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       adv, cap, load, bit_in;
  // a sweep step may only proceed when the output register is free this cycle
  assign adv = (state_q == SWEEP) && (!valid_q || tt_ready);
`ifdef TT_SWEEP_REG_IN_EN
  logic f_q, ph_q, ph_d;
  // ph_q=0: vector presented; ph_q=1: capture the registered value of that same vector
  assign ph_d   = (state_q == SWEEP) ? (ph_q ^ adv) : 1'b0;
  assign bit_in = f_q;
  assign cap    = adv && ph_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q  <= 1'b0;
      ph_q <= 1'b0;
    end else begin
      f_q  <= f_in;
      ph_q <= ph_d;
    end
  end
`else
  assign bit_in = f_in;
  assign cap    = adv;
`endif
  assign load = cap && (cnt_q == 3'd7);
  always_comb begin
    state_d = (state_q == IDLE)  ? (start ? SWEEP : IDLE) :
              (state_q == SWEEP) ? ((cap && idx_q == 7'd0) ? DRAIN : SWEEP) :
              (state_q == DRAIN) ? ((valid_q && tt_ready) ? DONE : DRAIN) : IDLE;
    // index 0 is terminal: never decrement past it
    idx_d   = (state_q == IDLE) ? 7'd127 : (cap && idx_q != 7'd0) ? idx_q - 7'd1 : idx_q;
    sr_d    = (state_q == IDLE) ? 7'd0 : cap ? {sr_q[5:0], bit_in} : sr_q;
    cnt_d   = (state_q == IDLE) ? 3'd0 : cap ? cnt_q + 3'd1 : cnt_q;
    data_d  = load ? {sr_q, bit_in} : data_q;
    valid_d = load || (valid_q && !tt_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 7'd127;
      sr_q    <= 7'd0;
      cnt_q   <= 3'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end
  assign {x6, x5, x4, x3, x2, x1, x0} = (state_q == SWEEP) ? idx_q : 7'd0;
  assign tt_data  = data_q;
  assign tt_valid = valid_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
endmodule

// File: tb/tb_tt_sweep.sv
// tb_tt_sweep: table-driven and randomized truth-table sweeps checked against the expected byte stream
module tb_tt_sweep;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tt_ready = 1'b1, f_in;
  logic x0, x1, x2, x3, x4, x5, x6, tt_valid, busy, done;
  logic [7:0] tt_data;
  logic [6:0] xv;
  int fmode = 0;
  logic [127:0] tbl = '0;
  int n_vec = 0, n_err = 0;
  localparam logic [127:0] GOLD = 128'hFEEAFCE8FCE8E880FEE8E8C0E8C0A880;
`ifdef TT_SWEEP_REG_IN_EN
  localparam int SW = 256;
`else
  localparam int SW = 128;
`endif
  typedef struct {
    int fm;
    int rm;
    bit poke;
    logic [127:0] exp;
  } vec_t;
  vec_t v[6];
  tt_sweep dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6),
    .f_in(f_in), .tt_data(tt_data), .tt_valid(tt_valid), .tt_ready(tt_ready),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  assign xv = {x6, x5, x4, x3, x2, x1, x0};
  always_comb f_in = (fmode == 1) ? x6 : (fmode == 2) ? x0 : (fmode == 0) ? 1'b0 : tbl[xv];
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // rm: 0 ready always high, 1 ready low 20 cycles on the third byte then random, 2 random
  task automatic run(input int rm, input bit poke, output logic [127:0] got, output int nb,
                     output int bc, output bit ok_st, output bit ok_dn, output bit ok_x, output bit fin);
    int stall = 0, acc = -2, ndone = 0, runs = 0, last = -1;
    bit hold = 0;
    logic [7:0] pd = '0;
    logic [6:0] px = '0;
    got = '0; nb = 0; bc = 0; ok_st = 1; ok_dn = 1; ok_x = 1; fin = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      if (!busy) begin
        fin = 1;
        start = 1'b0;
      end else begin
        if (hold && (!tt_valid || tt_data !== pd || xv !== px)) ok_st = 0;
        bc++;
        if (int'(xv) != last) begin
          if (int'(xv) != 127 - runs) ok_x = 0;
          runs++;
          last = int'(xv);
        end
        if (done) begin
          ndone++;
          if (c != acc + 1) ok_dn = 0;
        end
        if (rm == 0) tt_ready = 1'b1;
        else if (rm == 1 && nb == 2 && tt_valid && stall < 20) begin
          tt_ready = 1'b0;
          stall++;
        end else tt_ready = 1'($urandom_range(0, 1));
        if (poke) start = ($urandom_range(0, 2) == 0);
        if (tt_valid && tt_ready) begin
          if (nb < 16) got[127 - 8 * nb -: 8] = tt_data;
          nb++;
          if (nb == 16) acc = c;
        end
        hold = tt_valid && !tt_ready;
        pd = tt_data;
        px = xv;
        @(negedge clk);
      end
    end
    if (ndone != 1) ok_dn = 0;
    if (runs != 128) ok_x = 0;
    tt_ready = 1'b1;
  endtask
  initial begin
    logic [127:0] got;
    int nb, bc, nd;
    bit ok_st, ok_dn, ok_x, fin;
    v[0] = '{0, 0, 0, 128'h0};
    v[1] = '{1, 0, 0, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}};
    v[2] = '{2, 0, 0, {16{8'hAA}}};
    v[3] = '{3, 0, 0, GOLD};
    v[4] = '{3, 1, 0, GOLD};
    v[5] = '{2, 2, 1, {16{8'hAA}}};
    tbl = GOLD;
    rst = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", {busy, tt_valid, done, tt_data, xv}, '0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_state", {busy, done, xv}, '0);
    for (int i = 0; i < 6; i++) begin
      fmode = v[i].fm;
      run(v[i].rm, v[i].poke, got, nb, bc, ok_st, ok_dn, ok_x, fin);
      chk($sformatf("v%0d_finish", i), 128'(fin), 128'd1);
      chk($sformatf("v%0d_bytes", i), got, v[i].exp);
      chk($sformatf("v%0d_nbytes", i), 128'(nb), 128'd16);
      chk($sformatf("v%0d_xseq", i), 128'(ok_x), 128'd1);
      chk($sformatf("v%0d_done", i), 128'(ok_dn), 128'd1);
      chk($sformatf("v%0d_stall", i), 128'(ok_st), 128'd1);
      if (v[i].rm == 0) chk($sformatf("v%0d_sweeplen", i), 128'(bc - 2), 128'(SW));
    end
    for (int i = 0; i < 4; i++) begin
      fmode = 4;
      tbl = {$urandom, $urandom, $urandom, $urandom};
      run(2, 1'b0, got, nb, bc, ok_st, ok_dn, ok_x, fin);
      chk($sformatf("r%0d_bytes", i), got, tbl);
      chk($sformatf("r%0d_flags", i), {125'(nb), ok_st, ok_dn, ok_x}, {125'd16, 3'b111});
    end
    fmode = 3; tbl = GOLD; tt_ready = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk) rst = 1'b0;
    start = 1'b0;
    chk("abort_state", {busy, tt_valid, done, tt_data, xv}, '0);
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("abort_no_done", 128'(nd), 128'd0);
    run(0, 1'b1, got, nb, bc, ok_st, ok_dn, ok_x, fin);
    chk("after_abort_bytes", got, GOLD);
    chk("after_abort_flags", {125'(nb), ok_dn, ok_x, fin}, {125'd16, 3'b111});
    chk("after_abort_len", 128'(bc - 2), 128'(SW));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tt_sweep.md
TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 SHALL expose clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL expose rst, input, 1; one clock; reset is synchronous and active-high.
REQ-003 SHALL expose start, input, 1, request a truth-table sweep; sampled only in IDLE.
REQ-004 SHALL expose x0..x6, output, 1 each, input vector driven to the external 7-input function (x0 = LSB).
REQ-005 SHALL expose f_in, input, 1, function output for the vector currently on x0..x6.
REQ-006 SHALL expose tt_data, output, 8, truth-table byte.
REQ-007 SHALL expose tt_valid, output, 1, tt_data holds a byte.
REQ-008 SHALL expose tt_ready, input, 1, consumer accepts the byte when tt_valid=1 and tt_ready=1 in the same cycle.
REQ-009 SHALL expose busy, output, 1, high in every state except IDLE.
REQ-010 SHALL expose done, output, 1, one-cycle pulse when the sweep completes.

Function
REQ-011 SHALL implement states IDLE, SWEEP, DRAIN, DONE.
REQ-012 IDLE: x=0 and busy=0; start=1 moves to SWEEP with vector index 127, shift register and bit count cleared.
REQ-013 SWEEP: x0..x6 SHALL equal the index; each advancing cycle shifts f_in into the LSB of an 8-bit shift register, then decrements the index.
REQ-014 A cycle SHALL advance only if the output register is empty or is accepted in that cycle; otherwise x, the index, and the shift register hold.
REQ-015 On every 8th captured bit, the completed byte {7 earlier bits, f_in} SHALL load tt_data with tt_valid=1 on the next cycle; the first byte is bits 127..120, MSB first.
REQ-016 Exactly 16 bytes SHALL be emitted per sweep; the byte order is the hex truth-table string read left to right.
REQ-017 tt_data SHALL remain stable while tt_valid=1 and tt_ready=0; tt_valid SHALL clear on acceptance unless a new byte loads in the same cycle.
REQ-018 After index 0 is captured, the state SHALL go to DRAIN, then to DONE in the cycle after the 16th byte is accepted.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 With tt_ready held at 1, SWEEP SHALL last exactly 128 cycles.
REQ-021 start asserted while busy=1 SHALL be ignored.
REQ-022 The index SHALL not wrap: index 0 is terminal and no vector is presented twice in one sweep.

Reset
REQ-023 With rst=1 at a clock edge, the block SHALL enter IDLE with x=0, tt_data=0x00, tt_valid=0, busy=0, done=0, shift register and bit count 0.
REQ-024 Reset SHALL take priority over start and tt_ready.
REQ-025 Reset mid-sweep SHALL abort the sweep; partial bytes are discarded and there is no done pulse.

Configuration
REQ-026 Macro TT_SWEEP_REG_IN_EN defined: f_in SHALL pass through one register, and each vector is held for 2 advancing cycles (present, then capture from the registered value), so SWEEP lasts 256 cycles with tt_ready=1.
REQ-027 Macro TT_SWEEP_REG_IN_EN undefined: f_in SHALL be captured combinationally in the same cycle the vector is presented.
REQ-028 Byte contents and order SHALL be identical in both builds.

Verification
REQ-029 f_in tied 0, tt_ready=1, pulse start -> 16 bytes 0x00, done after the 16th acceptance, SWEEP exactly 128 cycles.
REQ-030 f_in=x6 -> bytes FF x8 then 00 x8; f_in=x0 -> 16 bytes 0xAA.
REQ-031 f_in from the golden network with table FEEAFCE8FCE8E880FEE8E8C0E8C0A880 -> bytes FE EA FC E8 FC E8 E8 80 FE E8 E8 C0 E8 C0 A8 80.
REQ-032 tt_ready low 20 cycles on byte 3, random afterwards -> tt_data stable while stalled, x frozen, same 16 bytes as with no stall.
REQ-033 rst at SWEEP cycle 50, then start -> no done pulse from the aborted run; the new run emits a complete, correct 16 bytes; start pulses during busy have no effect.
REQ-034 Build with TT_SWEEP_REG_IN_EN, rerun REQ-031 -> identical bytes, SWEEP 256 cycles.
